// File: rtl/fetch_stage.sv
// Instruction-fetch stage with IF/ID pipeline register. One outstanding request
// to a variable-latency instruction memory; handles stalls, flushes and redirects.
module fetch_stage #(
  parameter int              WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             PCsrc_E,
  input  logic [WIDTH-1:0] PCTarget_E,
  input  logic             stall_D,
  input  logic             flush_D,
  output logic             imem_req,
  output logic [WIDTH-1:0] imem_addr,
  input  logic             imem_rvalid,
  input  logic [WIDTH-1:0] imem_rdata,
  output logic [WIDTH-1:0] instr_D,
  output logic [WIDTH-1:0] PC_D,
  output logic [WIDTH-1:0] PCPlus4_D,
  output logic             valid_D,
  output logic             busy_F,
  output logic [1:0]       state_dbg
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  localparam logic [WIDTH-1:0] NOP = WIDTH'(32'h0000_0013);

  state_t           state, state_n;
  logic [WIDTH-1:0] pc_f, pc_n, pc_plus4;
  logic [WIDTH-1:0] hold_instr, hold_n;
  logic             load;
  logic [WIDTH-1:0] load_instr;
  logic             req;
  logic [WIDTH-1:0] addr;

  assign pc_plus4  = pc_f + WIDTH'(4);
  assign busy_F    = (state == S_WAIT) || (state == S_DROP);
  assign state_dbg = state;
  assign imem_req  = req;
  assign imem_addr = addr;

  // Handshake: a request is accepted in the cycle imem_req=1; exactly one
  // imem_rvalid answers it in a later cycle, and no new request is issued
  // until that answer is seen (except the back-to-back issue on its arrival).
  always_comb begin
    state_n    = state;
    pc_n       = pc_f;
    hold_n     = hold_instr;
    load       = 1'b0;
    load_instr = hold_instr;
    req        = 1'b0;
    addr       = pc_f;
    case (state)
      S_REQ: begin
        req = 1'b1;
        if (PCsrc_E) begin
          pc_n    = PCTarget_E;
          state_n = S_DROP;
        end else begin
          state_n = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          if (PCsrc_E) begin
            pc_n    = PCTarget_E;
            state_n = S_REQ;
          end else if (!stall_D) begin
            // Accept and immediately request the sequential successor.
            load       = 1'b1;
            load_instr = imem_rdata;
            pc_n       = pc_plus4;
            req        = 1'b1;
            addr       = pc_plus4;
          end else begin
            hold_n  = imem_rdata;
            state_n = S_HOLD;
          end
        end else if (PCsrc_E) begin
          pc_n    = PCTarget_E;
          state_n = S_DROP;
        end
      end
      S_DROP: begin
        if (PCsrc_E) pc_n = PCTarget_E;
        if (imem_rvalid) state_n = S_REQ;
      end
      S_HOLD: begin
        if (PCsrc_E) begin
          pc_n    = PCTarget_E;
          state_n = S_REQ;
        end else if (!stall_D) begin
          load    = 1'b1;
          pc_n    = pc_plus4;
          state_n = S_REQ;
        end
      end
      default: state_n = S_REQ;
    endcase
    if (!rst) req = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= S_REQ;
      pc_f       <= RESET_PC;
      hold_instr <= '0;
      instr_D    <= NOP;
      PC_D       <= '0;
      PCPlus4_D  <= '0;
      valid_D    <= 1'b0;
    end else begin
      state      <= state_n;
      pc_f       <= pc_n;
      hold_instr <= hold_n;
      if (flush_D || PCsrc_E) begin
        instr_D <= NOP;
        valid_D <= 1'b0;
      end else if (stall_D) begin
        instr_D <= instr_D;
      end else if (load) begin
        instr_D   <= load_instr;
        PC_D      <= pc_f;
        PCPlus4_D <= pc_plus4;
        valid_D   <= 1'b1;
      end else begin
        instr_D <= NOP;
        valid_D <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: variable-latency memory responder, program-order
// reference model with an expected-IF/ID queue, directed scenarios and random traffic.
module tb_fetch_stage;

  localparam int          W        = 32;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] KEY      = 32'hA5A5_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic          clk = 1'b0;
  logic          rst;
  logic          PCsrc_E;
  logic [W-1:0]  PCTarget_E;
  logic          stall_D;
  logic          flush_D;
  logic          imem_req;
  logic [W-1:0]  imem_addr;
  logic          imem_rvalid;
  logic [W-1:0]  imem_rdata;
  logic [W-1:0]  instr_D;
  logic [W-1:0]  PC_D;
  logic [W-1:0]  PCPlus4_D;
  logic          valid_D;
  logic          busy_F;
  logic [1:0]    state_dbg;

  fetch_stage #(.WIDTH(W), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst), .PCsrc_E(PCsrc_E), .PCTarget_E(PCTarget_E),
    .stall_D(stall_D), .flush_D(flush_D), .imem_req(imem_req),
    .imem_addr(imem_addr), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instr_D(instr_D), .PC_D(PC_D), .PCPlus4_D(PCPlus4_D), .valid_D(valid_D),
    .busy_F(busy_F), .state_dbg(state_dbg)
  );

  // clock / reset block
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // memory responder state
  int          lat;
  int          cnt;
  logic        pend;
  logic [31:0] pend_addr;
  logic        s_req;
  logic [31:0] s_addr;

  // reference model: next program-order PC, one buffered response, expected IF/ID
  logic [31:0] exp_pc;
  logic        have_buf;
  logic [31:0] buf_data;
  logic        ev;
  logic [31:0] epc, epc4, einstr;
  logic [96:0] exp_q[$];

  // One clock cycle: scoreboard checks at negedge, model update, memory response.
  task automatic cycle();
    logic [96:0] exp_v, act_v;
    logic        vr, dlv;
    logic [31:0] dd;
    @(negedge clk);
    s_req  = imem_req;
    s_addr = imem_addr;
    if (exp_q.size() != 0) begin
      exp_v = exp_q.pop_front();
      act_v = {valid_D, PC_D, PCPlus4_D, instr_D};
      checks++;
      if (act_v !== exp_v) begin
        errors++;
        $display("FAIL ifid: got v=%0b pc=%h pc4=%h instr=%h want v=%0b pc=%h pc4=%h instr=%h",
                 act_v[96], act_v[95:64], act_v[63:32], act_v[31:0],
                 exp_v[96], exp_v[95:64], exp_v[63:32], exp_v[31:0]);
      end
    end
    checks++;
    if (busy_F !== pend) begin
      errors++;
      $display("FAIL busy: got %0b want %0b", busy_F, pend);
    end
    if (!rst) begin
      checks++;
      if (s_req !== 1'b0) begin
        errors++;
        $display("FAIL req_in_reset: got %0b want 0", s_req);
      end
    end else begin
      if (pend && !imem_rvalid) begin
        checks++;
        if (s_req !== 1'b0) begin
          errors++;
          $display("FAIL overlap_req: got req=%0b want 0 (outstanding %h)", s_req, pend_addr);
        end
      end
      if (have_buf) begin
        checks++;
        if (s_req !== 1'b0) begin
          errors++;
          $display("FAIL hold_req: got req=%0b want 0", s_req);
        end
      end
    end
    if (!rst) begin
      exp_pc = RESET_PC; have_buf = 1'b0;
      ev = 1'b0; epc = '0; epc4 = '0; einstr = NOP;
    end else begin
      vr  = imem_rvalid && pend && (pend_addr == exp_pc) && !have_buf;
      dlv = 1'b0;
      dd  = '0;
      if (PCsrc_E) begin
        exp_pc = PCTarget_E; have_buf = 1'b0; ev = 1'b0; einstr = NOP;
      end else begin
        if (have_buf && !stall_D) begin
          dlv = 1'b1; dd = buf_data; have_buf = 1'b0;
        end else if (vr && stall_D) begin
          have_buf = 1'b1; buf_data = imem_rdata;
        end else if (vr) begin
          dlv = 1'b1; dd = imem_rdata;
        end
        if (flush_D) begin
          ev = 1'b0; einstr = NOP;
        end else if (!stall_D) begin
          if (dlv) begin
            ev = 1'b1; epc = exp_pc; epc4 = exp_pc + 32'd4; einstr = dd;
          end else begin
            ev = 1'b0; einstr = NOP;
          end
        end
        if (dlv) exp_pc = exp_pc + 32'd4;
      end
      if (s_req && !PCsrc_E) begin
        checks++;
        if (s_addr !== exp_pc) begin
          errors++;
          $display("FAIL req_addr: got %h want %h", s_addr, exp_pc);
        end
      end
    end
    exp_q.push_back({ev, epc, epc4, einstr});
    @(posedge clk);
    #1;
    if (!rst) pend = 1'b0;
    else begin
      if (imem_rvalid) pend = 1'b0;
      if (s_req) begin
        pend = 1'b1; pend_addr = s_addr; cnt = lat;
      end
    end
    imem_rvalid = 1'b0;
    if (pend) begin
      cnt--;
      if (cnt <= 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = pend_addr ^ KEY;
      end
    end
  endtask

  task automatic test_reset();
    @(posedge clk);
    #1;
    checks++;
    if ({valid_D, PC_D, PCPlus4_D, instr_D, busy_F} !== {1'b0, 32'h0, 32'h0, NOP, 1'b0}) begin
      errors++;
      $display("FAIL reset_vals: got v=%0b pc=%h pc4=%h instr=%h busy=%0b", valid_D, PC_D, PCPlus4_D, instr_D, busy_F);
    end
    exp_q.push_back({1'b0, 32'h0, 32'h0, NOP});
    cycle();
    checks++;
    if (s_req !== 1'b0) begin
      errors++;
      $display("FAIL reset_req: got %0b want 0", s_req);
    end
  endtask

  task automatic test_stream();
    lat = 1;
    rst = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cycle();
      checks++;
      if (s_req !== 1'b1 || s_addr !== 32'(4 * i)) begin
        errors++;
        $display("FAIL stream_req: got req=%0b addr=%h want 1 %h", s_req, s_addr, 32'(4 * i));
      end
      if (i > 0) begin
        checks++;
        if (valid_D !== 1'b1 || PC_D !== 32'(4 * (i - 1)) || PCPlus4_D !== 32'(4 * i) ||
            instr_D !== (32'(4 * (i - 1)) ^ KEY)) begin
          errors++;
          $display("FAIL stream_ifid: got v=%0b pc=%h pc4=%h instr=%h want pc=%h", valid_D, PC_D, PCPlus4_D, instr_D, 32'(4 * (i - 1)));
        end
      end
    end
  endtask

  task automatic test_stall();
    logic [31:0] p;
    p = PC_D;
    stall_D = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      checks++;
      if (s_req !== 1'b0 || PC_D !== p || valid_D !== 1'b1) begin
        errors++;
        $display("FAIL stall_hold: got req=%0b pc=%h v=%0b want 0 %h 1", s_req, PC_D, valid_D, p);
      end
    end
    stall_D = 1'b0;
    cycle();
    checks++;
    if (PC_D !== p + 32'd4 || instr_D !== ((p + 32'd4) ^ KEY) || valid_D !== 1'b1 || s_req !== 1'b0) begin
      errors++;
      $display("FAIL stall_release: got pc=%h instr=%h req=%0b want pc=%h", PC_D, instr_D, s_req, p + 32'd4);
    end
    cycle();
    checks++;
    if (s_req !== 1'b1 || s_addr !== p + 32'd8) begin
      errors++;
      $display("FAIL stall_next_req: got req=%0b addr=%h want 1 %h", s_req, s_addr, p + 32'd8);
    end
  endtask

  task automatic test_redirect_wait();
    logic found;
    lat = 3;
    cycle();
    cycle();
    PCsrc_E = 1'b1; PCTarget_E = 32'h100;
    cycle();
    PCsrc_E = 1'b0;
    checks++;
    if (busy_F !== 1'b1 || valid_D !== 1'b0) begin
      errors++;
      $display("FAIL redir_busy: got busy=%0b v=%0b want 1 0", busy_F, valid_D);
    end
    found = 1'b0;
    for (int k = 0; k < 8 && !found; k++) begin
      cycle();
      checks++;
      if (valid_D !== 1'b0) begin
        errors++;
        $display("FAIL redir_bubble: got v=%0b pc=%h want 0", valid_D, PC_D);
      end
      if (s_req) found = 1'b1;
    end
    checks++;
    if (!found || s_addr !== 32'h100) begin
      errors++;
      $display("FAIL redir_target_req: got found=%0b addr=%h want 1 00000100", found, s_addr);
    end
    found = 1'b0;
    for (int k = 0; k < 8 && !found; k++) begin
      cycle();
      if (valid_D) found = 1'b1;
    end
    checks++;
    if (!found || PC_D !== 32'h100 || instr_D !== (32'h100 ^ KEY)) begin
      errors++;
      $display("FAIL redir_target_instr: got v=%0b pc=%h instr=%h want pc=00000100", found, PC_D, instr_D);
    end
  endtask

  task automatic test_redirect_rvalid();
    logic        found;
    logic [31:0] old;
    lat = 1;
    for (int k = 0; k < 8 && !imem_rvalid; k++) cycle();
    checks++;
    if (imem_rvalid !== 1'b1) begin
      errors++;
      $display("FAIL rv_wait: got rvalid=%0b want 1 (timeout)", imem_rvalid);
    end
    old = pend_addr;
    PCsrc_E = 1'b1; PCTarget_E = 32'h200;
    cycle();
    PCsrc_E = 1'b0;
    checks++;
    if (valid_D !== 1'b0 || instr_D !== NOP) begin
      errors++;
      $display("FAIL rv_bubble: got v=%0b instr=%h want 0 %h", valid_D, instr_D, NOP);
    end
    cycle();
    checks++;
    if (s_req !== 1'b1 || s_addr !== 32'h200) begin
      errors++;
      $display("FAIL rv_target_req: got req=%0b addr=%h want 1 00000200", s_req, s_addr);
    end
    found = 1'b0;
    for (int k = 0; k < 8 && !found; k++) begin
      cycle();
      checks++;
      if (valid_D && PC_D === old) begin
        errors++;
        $display("FAIL rv_stale: got pc=%h reaching decode, want none", PC_D);
      end
      if (valid_D) found = 1'b1;
    end
    checks++;
    if (!found || PC_D !== 32'h200) begin
      errors++;
      $display("FAIL rv_target_instr: got v=%0b pc=%h want pc=00000200", found, PC_D);
    end
  endtask

  task automatic test_flush_stall();
    stall_D = 1'b1; flush_D = 1'b1;
    cycle();
    stall_D = 1'b0; flush_D = 1'b0;
    checks++;
    if (instr_D !== NOP || valid_D !== 1'b0) begin
      errors++;
      $display("FAIL flush_stall: got instr=%h v=%0b want %h 0", instr_D, valid_D, NOP);
    end
    cycle();
  endtask

  task automatic test_wrap();
    logic found;
    lat = 1;
    PCsrc_E = 1'b1; PCTarget_E = 32'hFFFF_FFFC;
    cycle();
    PCsrc_E = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 8 && !found; k++) begin
      cycle();
      if (valid_D) found = 1'b1;
    end
    checks++;
    if (!found || PC_D !== 32'hFFFF_FFFC || PCPlus4_D !== 32'h0) begin
      errors++;
      $display("FAIL wrap_top: got v=%0b pc=%h pc4=%h want fffffffc 00000000", found, PC_D, PCPlus4_D);
    end
    cycle();
    checks++;
    if (valid_D !== 1'b1 || PC_D !== 32'h0 || PCPlus4_D !== 32'h4) begin
      errors++;
      $display("FAIL wrap_next: got v=%0b pc=%h pc4=%h want 1 00000000 00000004", valid_D, PC_D, PCPlus4_D);
    end
  endtask

  task automatic test_reset_midflight();
    logic found;
    lat = 3;
    for (int k = 0; k < 6 && !busy_F; k++) cycle();
    rst = 1'b0;
    cycle();
    checks++;
    if ({valid_D, PC_D, PCPlus4_D, instr_D, busy_F} !== {1'b0, 32'h0, 32'h0, NOP, 1'b0}) begin
      errors++;
      $display("FAIL midreset_vals: got v=%0b pc=%h pc4=%h instr=%h busy=%0b", valid_D, PC_D, PCPlus4_D, instr_D, busy_F);
    end
    cycle();
    rst = 1'b1;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hDEAD_BEEF;
    cycle();
    checks++;
    if (s_req !== 1'b1 || s_addr !== RESET_PC || valid_D !== 1'b0) begin
      errors++;
      $display("FAIL midreset_restart: got req=%0b addr=%h v=%0b want 1 %h 0", s_req, s_addr, valid_D, RESET_PC);
    end
    found = 1'b0;
    for (int k = 0; k < 8 && !found; k++) begin
      cycle();
      if (valid_D) found = 1'b1;
    end
    checks++;
    if (!found || PC_D !== RESET_PC || instr_D !== (RESET_PC ^ KEY)) begin
      errors++;
      $display("FAIL midreset_first: got v=%0b pc=%h instr=%h want pc=%h", found, PC_D, instr_D, RESET_PC);
    end
  endtask

  task automatic test_random();
    logic [31:0] t;
    for (int n = 0; n < 400; n++) begin
      lat     = int'($urandom_range(1, 3));
      stall_D = ($urandom_range(0, 3) == 0);
      flush_D = ($urandom_range(0, 19) == 0);
      PCsrc_E = ($urandom_range(0, 19) == 0);
      t = 32'h1000 + (32'($urandom_range(0, 63)) << 2);
      while (t == exp_pc || t == pend_addr) t = t + 32'd8;
      PCTarget_E = t;
      cycle();
    end
    stall_D = 1'b0; flush_D = 1'b0; PCsrc_E = 1'b0;
    for (int n = 0; n < 8; n++) cycle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b0; PCsrc_E = 1'b0; PCTarget_E = '0; stall_D = 1'b0; flush_D = 1'b0;
    imem_rvalid = 1'b0; imem_rdata = '0;
    lat = 1; cnt = 0; pend = 1'b0; pend_addr = 32'hFFFF_FFF0;
    exp_pc = RESET_PC; have_buf = 1'b0; buf_data = '0;
    ev = 1'b0; epc = '0; epc4 = '0; einstr = NOP;
    test_reset();
    test_stream();
    test_stall();
    test_redirect_wait();
    test_redirect_rvalid();
    test_flush_stall();
    test_wrap();
    test_reset_midflight();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
